// File: rtl/PixelSensorConfig.sv
// -----------------------------------------------------------------------------
// PixelSensorConfig
// Shared configuration for the pixel array and its sequencer: array geometry,
// default phase lengths, and the sequencer state type.
// -----------------------------------------------------------------------------
package PixelSensorConfig;

    // Pixel array geometry
    localparam int PIXEL_ARRAY_HEIGHT = 2;
    localparam int PIXEL_ARRAY_WIDTH  = 2;
    localparam int PIXEL_BITS         = 8;

    // Derived widths. The row index is kept at least 1 bit wide so a
    // single-row array still has a legal out_row port.
    localparam int ROW_W  = (PIXEL_ARRAY_HEIGHT > 1) ? $clog2(PIXEL_ARRAY_HEIGHT) : 1;
    localparam int DATA_W = PIXEL_ARRAY_WIDTH * PIXEL_BITS;

    // Default phase lengths, in clock cycles
    localparam int C_ERASE_DEFAULT    = 5;
    localparam int C_EXPOSE_DEFAULT   = 255;
    localparam int C_CONVERT_DEFAULT  = 255;
    localparam int C_READ_ROW_DEFAULT = 5;

    // Width of the shared phase timer; bounds every phase length to 2**TIMER_W
    localparam int TIMER_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        ERASE,
        EXPOSE,
        CONVERT,
        READ,
        DONE
    } ctrl_state_t;

endpackage

// File: rtl/pixel_phase_timer.sv
// -----------------------------------------------------------------------------
// pixel_phase_timer
// Loadable down-counter shared by every phase and row duration of the
// sequencer. Loading value N-1 makes expire high in the N-th cycle after the
// load. Once at zero the counter holds, so expire stays high until the next
// load; the row readout relies on this to retry a stalled capture.
//
// Ports:
//   clk         clock, posedge
//   reset       synchronous active-low reset (count cleared)
//   load        load load_value this cycle
//   load_value  cycles remaining minus one
//   expire      current cycle is the last one of the loaded duration
// -----------------------------------------------------------------------------
module pixel_phase_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         expire
);

    logic [W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/pixel_sensor_ctrl.sv
// -----------------------------------------------------------------------------
// pixel_sensor_ctrl
// Sequences the pixel array through erase, expose, convert and row readout,
// then streams each captured row on a valid/ready interface.
//
// Ports:
//   clk, reset    clock and synchronous active-low reset
//   start         begin a frame (only honoured in IDLE)
//   continuous    at frame end, go straight to the next erase
//   erase         array ERASE
//   expose        array EXPOSE
//   ramp_en       convert active, gates the external ramp/DAC
//   read          one-hot row select to array READ
//   counter       digital ramp to array COUNTER (0 outside convert)
//   row_data      array DATA_OUT for the selected row
//   out_data      captured row
//   out_row       index of the row in out_data
//   out_valid     out_data valid
//   out_ready     downstream accepts when valid & ready
//   frame_done    one-cycle pulse after the last row is captured
//   busy          sequencer not in IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
module pixel_sensor_ctrl
    import PixelSensorConfig::*;
#(
    parameter int C_ERASE    = C_ERASE_DEFAULT,
    parameter int C_EXPOSE   = C_EXPOSE_DEFAULT,
    parameter int C_CONVERT  = C_CONVERT_DEFAULT,
    parameter int C_READ_ROW = C_READ_ROW_DEFAULT
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          continuous,
    output logic                          erase,
    output logic                          expose,
    output logic                          ramp_en,
    output logic [PIXEL_ARRAY_HEIGHT-1:0] read,
    output logic [7:0]                    counter,
    input  logic [DATA_W-1:0]             row_data,
    output logic [DATA_W-1:0]             out_data,
    output logic [ROW_W-1:0]              out_row,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          frame_done,
    output logic                          busy
);

    // Parameter sanity: the 8-bit counter must be able to reach C_CONVERT-1,
    // and every duration must fit the shared timer.
    if (C_CONVERT < 1 || C_CONVERT > 256) begin : g_bad_convert
        $error("pixel_sensor_ctrl: C_CONVERT must be in 1..256");
    end
    if (C_ERASE < 1 || C_ERASE > (1 << TIMER_W)) begin : g_bad_erase
        $error("pixel_sensor_ctrl: C_ERASE out of range");
    end
    if (C_EXPOSE < 1 || C_EXPOSE > (1 << TIMER_W)) begin : g_bad_expose
        $error("pixel_sensor_ctrl: C_EXPOSE out of range");
    end
    if (C_READ_ROW < 2 || C_READ_ROW > (1 << TIMER_W)) begin : g_bad_read_row
        $error("pixel_sensor_ctrl: C_READ_ROW out of range");
    end

    // Timer reload values: a phase of N cycles loads N-1
    localparam logic [TIMER_W-1:0] ERASE_LOAD   = TIMER_W'(C_ERASE - 1);
    localparam logic [TIMER_W-1:0] EXPOSE_LOAD  = TIMER_W'(C_EXPOSE - 1);
    localparam logic [TIMER_W-1:0] CONVERT_LOAD = TIMER_W'(C_CONVERT - 1);
    localparam logic [TIMER_W-1:0] ROW_LOAD     = TIMER_W'(C_READ_ROW - 1);

    localparam logic [PIXEL_ARRAY_HEIGHT-1:0] READ_FIRST = PIXEL_ARRAY_HEIGHT'(1);
    localparam logic [ROW_W-1:0]              ROW_LAST   = ROW_W'(PIXEL_ARRAY_HEIGHT - 1);

    ctrl_state_t        state;
    logic [ROW_W-1:0]   row;
    logic               expire;
    logic               timer_load;
    logic [TIMER_W-1:0] timer_value;
    logic               out_free;
    logic               capture;
    logic               last_row;

    // The output register can take a new row if it is empty or being drained
    // this very cycle.
    assign out_free = !out_valid || out_ready;
    assign capture  = (state == READ) && expire && out_free;
    assign last_row = (row == ROW_LAST);

    // Timer reloads on every phase entry and on every row advance. A stalled
    // row issues no reload, so the timer sits at zero and capture retries.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would infer a latch.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    timer_load  = 1'b1;
                    timer_value = ERASE_LOAD;
                end
            end
            ERASE: begin
                if (expire) begin
                    timer_load  = 1'b1;
                    timer_value = EXPOSE_LOAD;
                end
            end
            EXPOSE: begin
                if (expire) begin
                    timer_load  = 1'b1;
                    timer_value = CONVERT_LOAD;
                end
            end
            CONVERT: begin
                if (expire) begin
                    timer_load  = 1'b1;
                    timer_value = ROW_LOAD;
                end
            end
            READ: begin
                if (capture && !last_row) begin
                    timer_load  = 1'b1;
                    timer_value = ROW_LOAD;
                end
            end
            DONE: begin
                if (continuous) begin
                    timer_load  = 1'b1;
                    timer_value = ERASE_LOAD;
                end
            end
            default: ;
        endcase
    end

    pixel_phase_timer #(
        .W (TIMER_W)
    ) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .expire     (expire)
    );

    // Sequencer: every output is set on the edge that enters its phase, so
    // the outputs are registered and phases abut with no gap cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            row        <= '0;
            erase      <= 1'b0;
            expose     <= 1'b0;
            ramp_en    <= 1'b0;
            read       <= '0;
            counter    <= '0;
            // NOTE: out_data is an ordinary register, not a memory array, so
            // clearing it on reset is cheap and gives a defined bus after reset.
            out_data   <= '0;
            out_row    <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            frame_done <= 1'b0;

            // Drain on handshake; a capture below in the same cycle overrides
            // this and keeps out_valid high with the new row.
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        state <= ERASE;
                        erase <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                ERASE: begin
                    if (expire) begin
                        state  <= EXPOSE;
                        erase  <= 1'b0;
                        expose <= 1'b1;
                    end
                end
                EXPOSE: begin
                    if (expire) begin
                        state   <= CONVERT;
                        expose  <= 1'b0;
                        ramp_en <= 1'b1;
                        counter <= '0;
                    end
                end
                CONVERT: begin
                    if (expire) begin
                        state   <= READ;
                        ramp_en <= 1'b0;
                        counter <= '0;
                        row     <= '0;
                        read    <= READ_FIRST;
                    end else begin
                        counter <= counter + 8'd1;
                    end
                end
                READ: begin
                    if (capture) begin
                        out_data  <= row_data;
                        out_row   <= row;
                        out_valid <= 1'b1;
                        if (last_row) begin
                            state      <= DONE;
                            read       <= '0;
                            row        <= '0;
                            frame_done <= 1'b1;
                        end else begin
                            row  <= row + ROW_W'(1);
                            read <= read << 1;
                        end
                    end
                end
                DONE: begin
                    if (continuous) begin
                        state <= ERASE;
                        erase <= 1'b1;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    erase   <= 1'b0;
                    expose  <= 1'b0;
                    ramp_en <= 1'b0;
                    read    <= '0;
                    counter <= '0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_sensor_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pixel_sensor_ctrl
// Cycle n is the interval after the n-th posedge of a scenario; inputs are
// driven 1 time unit after the edge and outputs sampled on the negedge.
// A start held high in cycle 0 is sampled at edge 1, so erase is high 1..5.
// -----------------------------------------------------------------------------
module tb_pixel_sensor_ctrl;
    import PixelSensorConfig::*;

    localparam int H = PIXEL_ARRAY_HEIGHT;

    logic              clk;
    logic              reset;
    logic              start;
    logic              continuous;
    logic              erase;
    logic              expose;
    logic              ramp_en;
    logic [H-1:0]      read;
    logic [7:0]        counter;
    logic [DATA_W-1:0] row_data;
    logic [DATA_W-1:0] out_data;
    logic [ROW_W-1:0]  out_row;
    logic              out_valid;
    logic              out_ready;
    logic              frame_done;
    logic              busy;

    pixel_sensor_ctrl #(
        .C_ERASE    (5),
        .C_EXPOSE   (10),
        .C_CONVERT  (16),
        .C_READ_ROW (5)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .continuous (continuous),
        .erase      (erase),
        .expose     (expose),
        .ramp_en    (ramp_en),
        .read       (read),
        .counter    (counter),
        .row_data   (row_data),
        .out_data   (out_data),
        .out_row    (out_row),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_done (frame_done),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pixel array model: DATA_OUT shows the value of whichever row is selected
    logic [DATA_W-1:0] row_val [H];
    always_comb begin
        row_data = '0;
        if (read[0])      row_data = row_val[0];
        else if (read[1]) row_data = row_val[1];
    end

    // Scoreboard of expected output beats
    typedef struct {
        logic [ROW_W-1:0]  row;
        logic [DATA_W-1:0] data;
    } beat_t;
    beat_t sb[$];
    logic  mon_en = 1'b0;

    always @(negedge clk) begin
        if (mon_en && reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                errors++;
                checks++;
                $display("FAIL beat_unexpected: got row %0d data 0x%0h with empty scoreboard", out_row, out_data);
            end else begin
                beat_t e;
                e = sb.pop_front();
                check("beat_row", 64'(out_row), 64'(e.row));
                check("beat_data", 64'(out_data), 64'(e.data));
            end
        end
    end

    // Mutual exclusion of array controls and one-hot-or-zero read
    always @(negedge clk) begin
        if (mon_en && reset) begin
            logic ok;
            ok = ($countones({erase, expose, ramp_en, |read}) <= 1) && $onehot0(read);
            check("mutex", 64'(ok), 64'(1'b1));
        end
    end

    task automatic push_beat(input logic [ROW_W-1:0] r, input logic [DATA_W-1:0] d);
        beat_t b;
        b.row  = r;
        b.data = d;
        sb.push_back(b);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Packed observation: {erase, expose, ramp_en, read, counter, frame_done, busy, out_valid}
    function automatic logic [15:0] obs();
        return {erase, expose, ramp_en, read, counter, frame_done, busy, out_valid};
    endfunction

    // Phase window table for an unstalled frame started in cycle 0
    typedef struct {
        int         first;
        int         last;
        logic [2:0] ctl;   // {erase, expose, ramp_en}
        logic [1:0] rd;
        logic       done;
    } phase_vec_t;
    phase_vec_t ptab [6];

    function automatic logic [15:0] frame_expect(input int c);
        logic [15:0] v;
        v = '0;
        for (int i = 0; i < 6; i++) begin
            if (c >= ptab[i].first && c <= ptab[i].last) begin
                v[15:13] = ptab[i].ctl;
                v[12:11] = ptab[i].rd;
                v[2]     = ptab[i].done;
                v[1]     = 1'b1;
                if (ptab[i].ctl[0]) v[10:3] = 8'(c - ptab[i].first);
            end
        end
        v[0] = (c == 37) || (c == 42);
        return v;
    endfunction

    // Unstalled single frame, checked cycle by cycle against the phase table
    task automatic run_frame_check(input string tag, input logic [DATA_W-1:0] d0, input logic [DATA_W-1:0] d1);
        row_val[0] = d0;
        row_val[1] = d1;
        out_ready  = 1'b1;
        continuous = 1'b0;
        push_beat(1'b0, d0);
        push_beat(1'b1, d1);
        for (int c = 0; c <= 44; c++) begin
            start = (c == 0);
            @(negedge clk);
            check($sformatf("%s_c%0d", tag, c), 64'(obs()), 64'(frame_expect(c)));
            next_cycle();
        end
        check({tag, "_sb_drained"}, 64'(sb.size()), 64'd0);
    endtask

    // Backpressure expectations: {read, frame_done, busy, out_valid} and out_row
    typedef struct {
        int         cyc;
        logic [1:0] rd;
        logic       fd;
        logic       bsy;
        logic       ov;
        logic       row;
    } bp_vec_t;

    // Continuous expectations: {erase, ramp_en, counter, frame_done, busy}
    typedef struct {
        int         cyc;
        logic       er;
        logic       rmp;
        logic [7:0] cnt;
        logic       fd;
        logic       bsy;
    } cont_vec_t;

    initial begin
        bp_vec_t           bp [5];
        cont_vec_t         ct [8];
        logic [DATA_W-1:0] cv [6];

        ptab[0] = '{first: 1,  last: 5,  ctl: 3'b100, rd: 2'b00, done: 1'b0};
        ptab[1] = '{first: 6,  last: 15, ctl: 3'b010, rd: 2'b00, done: 1'b0};
        ptab[2] = '{first: 16, last: 31, ctl: 3'b001, rd: 2'b00, done: 1'b0};
        ptab[3] = '{first: 32, last: 36, ctl: 3'b000, rd: 2'b01, done: 1'b0};
        ptab[4] = '{first: 37, last: 41, ctl: 3'b000, rd: 2'b10, done: 1'b0};
        ptab[5] = '{first: 42, last: 42, ctl: 3'b000, rd: 2'b00, done: 1'b1};

        bp[0] = '{cyc: 37, rd: 2'b10, fd: 1'b0, bsy: 1'b1, ov: 1'b1, row: 1'b0};
        bp[1] = '{cyc: 45, rd: 2'b10, fd: 1'b0, bsy: 1'b1, ov: 1'b1, row: 1'b0};
        bp[2] = '{cyc: 50, rd: 2'b10, fd: 1'b0, bsy: 1'b1, ov: 1'b1, row: 1'b0};
        bp[3] = '{cyc: 51, rd: 2'b00, fd: 1'b1, bsy: 1'b1, ov: 1'b1, row: 1'b1};
        bp[4] = '{cyc: 52, rd: 2'b00, fd: 1'b0, bsy: 1'b0, ov: 1'b0, row: 1'b0};

        ct[0] = '{cyc: 21,  er: 1'b0, rmp: 1'b1, cnt: 8'd5, fd: 1'b0, bsy: 1'b1};
        ct[1] = '{cyc: 42,  er: 1'b0, rmp: 1'b0, cnt: 8'd0, fd: 1'b1, bsy: 1'b1};
        ct[2] = '{cyc: 43,  er: 1'b1, rmp: 1'b0, cnt: 8'd0, fd: 1'b0, bsy: 1'b1};
        ct[3] = '{cyc: 84,  er: 1'b0, rmp: 1'b0, cnt: 8'd0, fd: 1'b1, bsy: 1'b1};
        ct[4] = '{cyc: 85,  er: 1'b1, rmp: 1'b0, cnt: 8'd0, fd: 1'b0, bsy: 1'b1};
        ct[5] = '{cyc: 126, er: 1'b0, rmp: 1'b0, cnt: 8'd0, fd: 1'b1, bsy: 1'b1};
        ct[6] = '{cyc: 127, er: 1'b0, rmp: 1'b0, cnt: 8'd0, fd: 1'b0, bsy: 1'b0};
        ct[7] = '{cyc: 128, er: 1'b0, rmp: 1'b0, cnt: 8'd0, fd: 1'b0, bsy: 1'b0};

        cv[0] = 16'h1E2D; cv[1] = 16'h3C4B;
        cv[2] = 16'h5A69; cv[3] = 16'h7887;
        cv[4] = 16'h96A5; cv[5] = 16'hB4C3;

        // ---- Reset state ----
        reset      = 1'b0;
        start      = 1'b0;
        continuous = 1'b0;
        out_ready  = 1'b1;
        row_val[0] = '0;
        row_val[1] = '0;
        repeat (3) next_cycle();
        @(negedge clk);
        check("reset_outputs", 64'(obs()), 64'd0);
        check("reset_out_data", 64'(out_data), 64'd0);
        check("reset_out_row", 64'(out_row), 64'd0);
        check("reset_state", 64'(dut.state), 64'(IDLE));
        next_cycle();
        reset  = 1'b1;
        mon_en = 1'b1;
        next_cycle();

        // ---- Single frame with data path ----
        run_frame_check("frame1", 16'hA55A, 16'h0FF0);

        // ---- Backpressure: out_ready low in cycles 30..49 ----
        row_val[0] = 16'h1234;
        row_val[1] = 16'h5678;
        push_beat(1'b0, 16'h1234);
        push_beat(1'b1, 16'h5678);
        for (int c = 0; c <= 52; c++) begin
            start     = (c == 0);
            out_ready = !(c >= 30 && c < 50);
            @(negedge clk);
            for (int i = 0; i < 5; i++) begin
                if (bp[i].cyc == c) begin
                    check($sformatf("bp_ctl_c%0d", c), 64'({read, frame_done, busy, out_valid}),
                          64'({bp[i].rd, bp[i].fd, bp[i].bsy, bp[i].ov}));
                    if (bp[i].ov) check($sformatf("bp_row_c%0d", c), 64'(out_row), 64'(bp[i].row));
                end
            end
            if (c == 45) check("bp_data_held", 64'(out_data), 64'h1234);
            if (c == 51) check("bp_data_row1", 64'(out_data), 64'h5678);
            next_cycle();
        end
        check("bp_sb_drained", 64'(sb.size()), 64'd0);

        // ---- Continuous: three frames, stray starts while busy ----
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) push_beat(ROW_W'(i % 2), cv[i]);
        row_val[0] = cv[0];
        row_val[1] = cv[1];
        for (int c = 0; c <= 128; c++) begin
            start      = (c == 0) || (c == 20) || (c == 126);
            continuous = (c < 100);
            if (c == 43) begin row_val[0] = cv[2]; row_val[1] = cv[3]; end
            if (c == 85) begin row_val[0] = cv[4]; row_val[1] = cv[5]; end
            @(negedge clk);
            for (int i = 0; i < 8; i++) begin
                if (ct[i].cyc == c) begin
                    check($sformatf("cont_c%0d", c), 64'({erase, ramp_en, counter, frame_done, busy}),
                          64'({ct[i].er, ct[i].rmp, ct[i].cnt, ct[i].fd, ct[i].bsy}));
                end
            end
            next_cycle();
        end
        start      = 1'b0;
        continuous = 1'b0;
        check("cont_sb_drained", 64'(sb.size()), 64'd0);

        // ---- Reset in the middle of convert, then a fresh frame ----
        for (int c = 0; c <= 24; c++) begin
            start = (c == 0);
            reset = !(c == 23);
            @(negedge clk);
            if (c == 23) check("rst_pre_counter", 64'({ramp_en, counter}), 64'({1'b1, 8'd7}));
            if (c == 24) begin
                check("rst_outputs", 64'(obs()), 64'd0);
                check("rst_out_data", 64'(out_data), 64'd0);
                check("rst_state", 64'(dut.state), 64'(IDLE));
            end
            next_cycle();
        end
        reset = 1'b1;
        run_frame_check("frame_after_rst", 16'hC3E1, 16'h7E18);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
